// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array blocks: the feeder state
// encoding and the anti-diagonal count of an NxN array.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } feeder_state_t;

  // An NxN grid has 2N-1 anti-diagonals (i+j = 0 .. 2N-2).
  function automatic int DIAGS(input int n);
    return 2 * n - 1;
  endfunction

endpackage

// File: rtl/skew_line.sv
// Fixed-depth shift register with enable; all stages clear on reset.
// One instance per operand lane gives that lane its systolic skew.
module skew_line #(
  parameter int DW    = 8,
  parameter int DEPTH = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] stage_reg [DEPTH];

  // Shift one stage per enabled cycle; hold when disabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < DEPTH; s++) begin
        stage_reg[s] <= '0;
      end
    end else if (en) begin
      stage_reg[0] <= din;
      for (int s = 1; s < DEPTH; s++) begin
        stage_reg[s] <= stage_reg[s-1];
      end
    end
  end

  assign dout = stage_reg[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// Operand sequencer for an NxN output-stationary systolic MAC array.
// Accepts one K-slice per beat (A column + B row), skews lane i by i+1
// cycles, injects zeros on bubbles and during the flush, and pulses one
// result-capture bit per anti-diagonal at the end of every tile.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int N  = 2,
  parameter int DW = 8,
  parameter int KW = 17,
  parameter int TW = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [KW-1:0]         k_len,
  input  logic [TW-1:0]         num_tiles,
  input  logic [N*DW-1:0]       a_in,
  input  logic [N*DW-1:0]       b_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [N*DW-1:0]       a_out,
  output logic [N*DW-1:0]       b_out,
  output logic [DIAGS(N)-1:0]   push_diag,
  output logic [TW-1:0]         tile_idx,
  output logic                  busy,
  output logic                  done
);

  localparam int ND = DIAGS(N);
  // Flush counter runs 0 .. 2N-1.
  localparam int FW = $clog2(2 * N);
  localparam logic [FW-1:0] F_LAST = FW'(2 * N - 1);

  feeder_state_t state_reg, state_next;
  logic [KW-1:0] step_reg, step_next;
  logic [FW-1:0] f_reg, f_next;
  logic [TW-1:0] tile_idx_reg, tile_idx_next;
  logic [KW-1:0] k_len_reg, k_len_next;
  logic [TW-1:0] num_tiles_reg, num_tiles_next;

  logic accept;
  logic shift_en;

  assign in_ready = (state_reg == FEED);
  assign accept   = in_valid & in_ready;
  // Skew lines advance while a tile is being fed or drained, hold otherwise.
  assign shift_en = (state_reg == FEED) || (state_reg == FLUSH);
  assign busy     = (state_reg != IDLE);
  assign done     = (state_reg == DONE);
  assign tile_idx = tile_idx_reg;

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      step_reg      <= '0;
      f_reg         <= '0;
      tile_idx_reg  <= '0;
      k_len_reg     <= '0;
      num_tiles_reg <= '0;
    end else begin
      state_reg     <= state_next;
      step_reg      <= step_next;
      f_reg         <= f_next;
      tile_idx_reg  <= tile_idx_next;
      k_len_reg     <= k_len_next;
      num_tiles_reg <= num_tiles_next;
    end
  end

  // Next-state and counter update logic.
  always_comb begin
    state_next     = state_reg;
    step_next      = step_reg;
    f_next         = f_reg;
    tile_idx_next  = tile_idx_reg;
    k_len_next     = k_len_reg;
    num_tiles_next = num_tiles_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          k_len_next     = k_len;
          num_tiles_next = num_tiles;
          tile_idx_next  = '0;
          step_next      = '0;
          f_next         = '0;
          // An empty job (no beats or no tiles) completes immediately.
          if ((k_len == '0) || (num_tiles == '0)) begin
            state_next = DONE;
          end else begin
            state_next = FEED;
          end
        end
      end
      FEED: begin
        if (accept) begin
          // step stays at k_len-1 on the last beat; it is cleared per tile.
          if (step_reg == k_len_reg - KW'(1)) begin
            state_next = FLUSH;
            f_next     = '0;
          end else begin
            step_next = step_reg + KW'(1);
          end
        end
      end
      FLUSH: begin
        if (f_reg == F_LAST) begin
          if (tile_idx_reg == num_tiles_reg - TW'(1)) begin
            state_next = DONE;
          end else begin
            tile_idx_next = tile_idx_reg + TW'(1);
            step_next     = '0;
            state_next    = FEED;
          end
        end else begin
          f_next = f_reg + FW'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  genvar gi;

  // Operand lanes: lane 0 of each skew line takes the beat or a zero bubble,
  // and lane i is i+1 registers deep.
  for (gi = 0; gi < N; gi++) begin : g_lane
    logic [DW-1:0] a_inj;
    logic [DW-1:0] b_inj;

    assign a_inj = accept ? a_in[gi*DW +: DW] : '0;
    assign b_inj = accept ? b_in[gi*DW +: DW] : '0;

    skew_line #(
      .DW    (DW),
      .DEPTH (gi + 1)
    ) u_a_skew (
      .clk   (clk),
      .reset (reset),
      .en    (shift_en),
      .din   (a_inj),
      .dout  (a_out[gi*DW +: DW])
    );

    skew_line #(
      .DW    (DW),
      .DEPTH (gi + 1)
    ) u_b_skew (
      .clk   (clk),
      .reset (reset),
      .en    (shift_en),
      .din   (b_inj),
      .dout  (b_out[gi*DW +: DW])
    );
  end

  // Anti-diagonal d has seen its last product by flush cycle d+1.
  for (gi = 0; gi < ND; gi++) begin : g_push
    assign push_diag[gi] = (state_reg == FLUSH) && (f_reg == FW'(gi + 1));
  end

endmodule
